// File: rtl/pwm_fader.sv
// pwm_fader -- duty-cycle sequencer for a shared PWM modulator.
//
// Keeps a period counter that mirrors the modulator's state counter and walks
// the modulator's duty input from its current value to a requested target in
// programmable steps. Duty only changes on the last state of a period, so the
// modulator always sees one constant duty for a whole period.
//
// Parameters:
//   period - PWM states per period (>= 2); n = $clog2(period)
//   rate_w - width of the rate input
//
// Ports:
//   clk    in   PWM clock
//   rst_n  in   asynchronous active-low reset
//   target in   requested final duty (clamped to period)
//   step   in   duty change per update (0 is treated as 1)
//   rate   in   PWM periods per update, minus one
//   start  in   begin a fade (ignored while busy)
//   abort  in   cancel a running fade, duty holds; wins over start
//   duty   out  current duty, feeds the modulator
//   sync   out  high in the last state of each period
//   busy   out  fade in progress
//   done   out  one-cycle pulse when a fade reaches its target
//   out    out  only with PWM_FADER_OUT_EN: built-in PWM, out = duty > cnt
//
// Optional feature macro: PWM_FADER_OUT_EN (adds the out port).
module pwm_fader #(
  parameter int period = 16,
  parameter int rate_w = 8,
  localparam int n = $clog2(period)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [n-1:0]      target,
  input  logic [n-1:0]      step,
  input  logic [rate_w-1:0] rate,
  input  logic              start,
  input  logic              abort,
  output logic [n-1:0]      duty,
  output logic              sync,
  output logic              busy,
  output logic              done
`ifdef PWM_FADER_OUT_EN
  ,
  output logic              out
`endif
);

  localparam int nw = n + 1;
  localparam logic [n-1:0]  cnt_max = n'(period - 1);
  localparam logic [nw-1:0] tgt_cap = nw'(period);

  typedef enum logic [0:0] {IDLE = 1'b0, FADE = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [n-1:0]        cnt_r;
  logic [n-1:0]        duty_r, duty_s;
  logic [n-1:0]        tgt_r, tgt_s;
  logic [n-1:0]        stp_r, stp_s;
  logic [rate_w-1:0]   rate_r, rate_s;
  logic [rate_w-1:0]   pre_r, pre_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  logic [nw-1:0]       req_x;
  logic [n-1:0]        req_tgt_s;
  logic [n-1:0]        req_stp_s;
  logic [nw-1:0]       duty_x, tgt_x, stp_x, sum_x, dif_x, move_x;

  assign sync = (cnt_r == cnt_max);
  assign duty = duty_r;
  assign busy = busy_r;
  assign done = done_r;

`ifdef PWM_FADER_OUT_EN
  assign out = (duty_r > cnt_r);
`endif

  // period counter, wraps exactly like the modulator's state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {n{1'b0}};
    end else if (sync) begin
      cnt_r <= {n{1'b0}};
    end else begin
      cnt_r <= cnt_r + n'(1);
    end
  end

  // request conditioning: clamp target to period, promote step 0 to 1
  always_comb begin
    req_x = {1'b0, target};
    if (req_x > tgt_cap) begin
      req_tgt_s = tgt_cap[n-1:0];
    end else begin
      req_tgt_s = target;
    end
    if (step == {n{1'b0}}) begin
      req_stp_s = n'(1);
    end else begin
      req_stp_s = step;
    end
  end

  // one saturating step toward the target, one bit wider so it cannot wrap
  always_comb begin
    duty_x = {1'b0, duty_r};
    tgt_x  = {1'b0, tgt_r};
    stp_x  = {1'b0, stp_r};
    sum_x  = duty_x + stp_x;
    dif_x  = duty_x - tgt_x;
    if (duty_x < tgt_x) begin
      if (sum_x > tgt_x) begin
        move_x = tgt_x;
      end else begin
        move_x = sum_x;
      end
    end else begin
      if (dif_x <= stp_x) begin
        move_x = tgt_x;
      end else begin
        move_x = duty_x - stp_x;
      end
    end
  end

  // next-state and output decode for the IDLE/FADE sequencer
  always_comb begin
    state_s = state_r;
    duty_s  = duty_r;
    tgt_s   = tgt_r;
    stp_s   = stp_r;
    rate_s  = rate_r;
    pre_s   = pre_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          tgt_s  = req_tgt_s;
          stp_s  = req_stp_s;
          rate_s = rate;
          pre_s  = {rate_w{1'b0}};
          // nothing to do: report completion without ever going busy
          if (req_tgt_s == duty_r) begin
            done_s = 1'b1;
          end else begin
            state_s = FADE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FADE: begin
        if (abort) begin
          state_s = IDLE;
          pre_s   = {rate_w{1'b0}};
        end else if (sync) begin
          if (pre_r != rate_r) begin
            pre_s = pre_r + rate_w'(1);
          end else begin
            pre_s  = {rate_w{1'b0}};
            duty_s = move_x[n-1:0];
            if (move_x == tgt_x) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = FADE;
            end
          end
        end else begin
          state_s = FADE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == FADE);
  end

  // sequencer state, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      duty_r  <= {n{1'b0}};
      tgt_r   <= {n{1'b0}};
      stp_r   <= {n{1'b0}};
      rate_r  <= {rate_w{1'b0}};
      pre_r   <= {rate_w{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      duty_r  <= duty_s;
      tgt_r   <= tgt_s;
      stp_r   <= stp_s;
      rate_r  <= rate_s;
      pre_r   <= pre_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader (period 16 main instance, period 10
// instance for the target clamp). Expected timing comes from a schedule model:
// sync edges are the multiples of the period counted from reset release, and
// update i of a fade lands on sync edge i*(rate+1) after the start edge.
module tb_pwm_fader;
  localparam int P  = 16;
  localparam int N  = 4;
  localparam int P2 = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] target, step;
  logic [7:0]   rate;
  logic         start, abort;
  logic [N-1:0] duty;
  logic         sync, busy, done;
  logic [3:0]   target10, step10;
  logic [7:0]   rate10;
  logic         start10, abort10;
  logic [3:0]   duty10;
  logic         sync10, busy10, done10;
`ifdef PWM_FADER_OUT_EN
  logic         out, out10;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  int model_duty = 0;
  int seen_q[$];

  pwm_fader #(.period(P), .rate_w(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .target(target), .step(step), .rate(rate),
    .start(start), .abort(abort), .duty(duty), .sync(sync), .busy(busy),
    .done(done)
`ifdef PWM_FADER_OUT_EN
    , .out(out)
`endif
  );

  pwm_fader #(.period(P2), .rate_w(8)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .target(target10), .step(step10), .rate(rate10),
    .start(start10), .abort(abort10), .duty(duty10), .sync(sync10),
    .busy(busy10), .done(done10)
`ifdef PWM_FADER_OUT_EN
    , .out(out10)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int s;
    int r;
    int n_up;
    int seq[3];
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check_cycle(input int ed, input int eb, input int edn);
    check("duty", int'(duty), ed);
    check("busy", int'(busy), eb);
    check("done", int'(done), edn);
    check("sync", int'(sync), ((k % P) == P - 1) ? 1 : 0);
`ifdef PWM_FADER_OUT_EN
    check("out", int'(out), (ed > (k % P)) ? 1 : 0);
`endif
  endtask

  task automatic idle_gap(input int nc);
    for (int c = 0; c < nc; c++) begin
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));
      tick();
      check_cycle(model_duty, 0, 0);
    end
    abort = 1'b0;
  endtask

  task automatic run_fade(input int t, input int s, input int r, input bit noise);
    int tg, sp, d, ks, kf, m1, ed, prev;
    int ups_v[$];
    int ups_e[$];
    tg = (t > P) ? P : t;
    sp = (s == 0) ? 1 : s;
    d  = model_duty;
    ks = k + 1;
    m1 = (ks / P + 1) * P;
    while (d != tg) begin
      if (d < tg) d = (d + sp > tg) ? tg : d + sp;
      else        d = (d - sp < tg) ? tg : d - sp;
      ups_v.push_back(d);
      ups_e.push_back(m1 + (ups_v.size() * (r + 1) - 1) * P);
    end
    kf = (ups_v.size() == 0) ? ks : ups_e[ups_e.size() - 1];
    seen_q.delete();
    prev   = model_duty;
    target = 4'(t);
    step   = 4'(s);
    rate   = 8'(r);
    start  = 1'b1;
    abort  = 1'b0;
    tick();
    start = 1'b0;
    while (1) begin
      ed = model_duty;
      foreach (ups_e[i]) if (ups_e[i] <= k) ed = ups_v[i];
      check_cycle(ed, (ups_v.size() != 0 && k < kf) ? 1 : 0, (k == kf) ? 1 : 0);
      if (int'(duty) != prev) begin
        seen_q.push_back(int'(duty));
        prev = int'(duty);
      end
      if (k >= kf + 2) break;
      if (noise) begin
        target = 4'($urandom);
        step   = 4'($urandom);
        rate   = 8'($urandom_range(0, 255));
        start  = ((k + 1) < kf) && ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    start = 1'b0;
    model_duty = tg;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    int c;
    tbl[0] = '{t: 12, s: 4,  r: 0, n_up: 3, seq: '{4, 8, 12}};
    tbl[1] = '{t: 1,  s: 5,  r: 1, n_up: 3, seq: '{7, 2, 1}};
    tbl[2] = '{t: 1,  s: 0,  r: 0, n_up: 0, seq: '{0, 0, 0}};
    tbl[3] = '{t: 4,  s: 0,  r: 0, n_up: 3, seq: '{2, 3, 4}};
    tbl[4] = '{t: 15, s: 7,  r: 0, n_up: 2, seq: '{11, 15, 0}};
    tbl[5] = '{t: 0,  s: 15, r: 2, n_up: 1, seq: '{0, 0, 0}};
    tbl[6] = '{t: 9,  s: 4,  r: 3, n_up: 3, seq: '{4, 8, 9}};

    rst_n = 1'b0;
    target = 4'd0; step = 4'd0; rate = 8'd0; start = 1'b0; abort = 1'b0;
    target10 = 4'd0; step10 = 4'd0; rate10 = 8'd0; start10 = 1'b0; abort10 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    check_cycle(0, 0, 0);

    // directed fades; table order chains each start duty from the previous end
    for (int i = 0; i < 7; i++) begin
      run_fade(tbl[i].t, tbl[i].s, tbl[i].r, 1'b0);
      check("tbl_nupd", seen_q.size(), tbl[i].n_up);
      for (int j = 0; j < tbl[i].n_up; j++)
        check("tbl_seq", (j < seen_q.size()) ? seen_q[j] : -1, tbl[i].seq[j]);
    end
    idle_gap(20);

    // start and abort together in IDLE: nothing starts
    target = 4'(model_duty + 5);
    step = 4'd1; rate = 8'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_cycle(model_duty, 0, 0);
    idle_gap(20);

    // abort at duty 3, duty holds, no done, next start accepted
    run_fade(0, 15, 0, 1'b0);
    target = 4'd15; step = 4'd1; rate = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 200 && duty != 4'd3; c++) tick();
    check("abort_reach3", int'(duty), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_cycle(3, 0, 0);
    model_duty = 3;
    for (c = 0; c < 40; c++) begin
      tick();
      check_cycle(3, 0, 0);
    end
    run_fade(5, 1, 0, 1'b0);
    check("after_abort_nupd", seen_q.size(), 2);

    // randomized fades with input noise and ignored restarts mid-fade
    for (int i = 0; i < 25; i++) begin
      run_fade($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'b1);
      idle_gap($urandom_range(1, 20));
    end

    // period-10 instance: target 13 clamps to 10
    target10 = 4'd13; step10 = 4'd4; rate10 = 8'd0; start10 = 1'b1;
    tick();
    start10 = 1'b0;
    dones = 0;
    for (c = 0; c < 100; c++) begin
      tick();
      check("sync10", int'(sync10), ((k % P2) == P2 - 1) ? 1 : 0);
      if (done10) begin
        dones++;
        break;
      end
    end
    check("clamp_done", dones, 1);
    check("clamp_duty", int'(duty10), 10);
    check("clamp_busy", int'(busy10), 0);
    for (c = 0; c < 25; c++) begin
      tick();
      check("clamp_hold", int'(duty10), 10);
      check("clamp_done_once", int'(done10), 0);
`ifdef PWM_FADER_OUT_EN
      check("clamp_out", int'(out10), 1);
`endif
    end

    // asynchronous reset in the middle of a fade at duty 6
    run_fade(0, 15, 0, 1'b0);
    target = 4'd15; step = 4'd1; rate = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 200 && duty != 4'd6; c++) tick();
    check("rst_reach6", int'(duty), 6);
    check("rst_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sync", int'(sync), 0);
`ifdef PWM_FADER_OUT_EN
    check("rst_out", int'(out), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    model_duty = 0;
    for (c = 0; c < 16; c++) begin
      tick();
      check_cycle(0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
